triangle_divisor_search: RTL and testbench
==========================================

# triangle_divisor_search

Sequencer that drives one `factor_count` instance to find the first triangular number T(n) = n(n+1)/2 whose divisor count strictly exceeds a programmable threshold (Project Euler 12). It generates successive triangular numbers, issues each to the divisor counter with a clean start edge, waits for completion, and compares. It sits directly above `factor_count`, owns that instance's `start`/`value` inputs exclusively, and reports the first hit, an overflow, or a timeout.

## Interface
- `VALUE_W`, 32: width of triangular-number accumulator, 8..32; values zero-extended onto `fc_value`.
- `TIMEOUT_CYCLES`, 0: per-evaluation watchdog in clocks; 0 disables.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin search; sampled only in IDLE; ignored otherwise.
- `threshold` in 32: divisor-count bound; captured on accepted `start`.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: level; high when search ends; cleared on next accepted `start`.
- `error` out 2: valid with `done`; 0 = found, 1 = accumulator overflow, 2 = timeout.
- `found_index` out 32: n of result (or last n attempted on error).
- `found_value` out 32: T(n) zero-extended (0 on overflow).
- `found_divisors` out 32: `fc_result` for T(n) (0 on error).
- `fc_start` out 1: to `factor_count.start`.
- `fc_value` out 32: to `factor_count.value`.
- `fc_result` in 32: from `factor_count.result`.
- `fc_done` in 1: from `factor_count.done`.

## Operation
- States: IDLE, ADVANCE, ISSUE, WAIT_CLR, WAIT_DONE, CHECK, FINISH.
- Reset: state IDLE; `busy`,`done`,`fc_start` = 0; `error`,`found_*`,`fc_value` = 0; internal n = 0, T = 0, watchdog = 0.
- IDLE: on `start`=1 capture `threshold`, n<=0, T<=0, `done`<=0, `error`<=0, `busy`<=1, go ADVANCE.
- ADVANCE: n<=n+1, T<=T+n+1 computed at VALUE_W+1 bits; if carry out set, `error`<=1, go FINISH; else `fc_value`<=new T, go ISSUE.
- ISSUE: `fc_start`=1 for exactly one cycle; go WAIT_CLR. `fc_start` is 0 in every other state, guaranteeing a low cycle before each rising edge (divisor counter is edge-triggered on `start`).
- WAIT_CLR: wait for `fc_done`=0 (stale done from previous evaluation must be discarded); then WAIT_DONE.
- WAIT_DONE: on `fc_done`=1 go CHECK.
- CHECK: if `fc_result` > captured threshold (unsigned): `found_index`<=n, `found_value`<=T, `found_divisors`<=`fc_result`, go FINISH; else go ADVANCE.
- FINISH: `done`<=1, `busy`<=0, go IDLE. On error, `found_index` = n attempted, `found_value`/`found_divisors` = 0.
- Watchdog: counts cycles in WAIT_CLR+WAIT_DONE, reset in ISSUE; reaching TIMEOUT_CYCLES (nonzero) sets `error`<=2, go FINISH.
- `fc_value` is never 0 (divisor counter would never terminate on 0); held stable from ADVANCE through CHECK.
- Reset mid-search: all state/outputs to reset values immediately; the divisor counter has no reset, its in-flight run is abandoned and overridden by the next ISSUE edge.

## Timing
- `start`→`busy`: 1 cycle. Controller overhead per candidate: ADVANCE+ISSUE+CHECK = 3 cycles plus WAIT_CLR/WAIT_DONE duration.
- `fc_start` rises the cycle after ADVANCE; `fc_done` is expected low from the cycle after ISSUE.
- CHECK→FINISH→IDLE: `done` visible 2 cycles after the hit's `fc_done` sample; `found_*` valid same cycle as `done` and held until next accepted `start`.
- `start` held high through FINISH does not retrigger until state returns to IDLE; holding it in IDLE starts a new search, clearing `done` next cycle.
- Threshold comparison strictly greater-than; threshold 0 hits at n=1.

## Test plan
- threshold=5, VALUE_W=32 → `done`, `error`=0, `found_index`=7, `found_value`=28, `found_divisors`=6.
- threshold=0 → n=1, T=1, divisors=1; threshold=3 → n=3, T=6, divisors=4.
- threshold=500 → n=12375, T=76576500, divisors=576; `fc_start` never high two consecutive cycles; `fc_value` never 0.
- VALUE_W=16, threshold=1000 → `error`=1 at n=362 (T(361)=65341 last valid), `found_value`=0, `busy` low.
- TIMEOUT_CYCLES=4 with stub divisor counter never asserting `fc_done` → `error`=2, n=1; `start` pulsed while busy in any run → ignored, results unchanged.
- Assert `rst_n`=0 mid-WAIT_DONE at threshold=500 → all outputs 0 immediately; restart with threshold=5 → correct n=7 result despite stale `fc_done`.

Source files
------------

// File: rtl/triangle_divisor_search.sv
// Purpose: walks T(n)=n(n+1)/2 through an external divisor counter and stops at the first T whose divisor count exceeds threshold.
// Latency: start->busy 1 clk; per candidate 3 clks + counter run time; done 2 clks after the hit's fc_done sample.
// Backpressure: start is only sampled in IDLE; a busy search ignores start until done, and results hold until the next accepted start.
// Ports: start/threshold launch a search; busy/done/error/found_* report it;
//        fc_start/fc_value drive the divisor counter, fc_result/fc_done return its answer.
module triangle_divisor_search #(
    parameter int VALUE_W        = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] threshold,
    output logic        busy,
    output logic        done,
    output logic [1:0]  error,
    output logic [31:0] found_index,
    output logic [31:0] found_value,
    output logic [31:0] found_divisors,
    output logic        fc_start,
    output logic [31:0] fc_value,
    input  logic [31:0] fc_result,
    input  logic        fc_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADVANCE,
        S_ISSUE,
        S_WAIT_CLR,
        S_WAIT_DONE,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t             state;
    logic [31:0]        thr_q;
    logic [31:0]        n_q;
    logic [VALUE_W-1:0] t_q;
    logic [31:0]        wd_q;

    logic [31:0]        n_inc;
    logic [32:0]        t_wide;
    logic               ovf;
    logic               wd_hit;

    // Next triangular number at 33 bits; any bit at or above VALUE_W means
    // the accumulator cannot hold it. n+1 never exceeds T(n+1), so the
    // narrow-accumulator case is covered by the same test.
    assign n_inc  = n_q + 32'd1;
    assign t_wide = {1'b0, 32'(t_q)} + {1'b0, n_q} + 33'd1;
    assign ovf    = |t_wide[32:VALUE_W];

    // Fires on the TIMEOUT_CYCLES-th cycle spent waiting on the counter.
    assign wd_hit = (TIMEOUT_CYCLES != 0) && ((wd_q + 32'd1) == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 2'd0;
            found_index    <= 32'd0;
            found_value    <= 32'd0;
            found_divisors <= 32'd0;
            fc_start       <= 1'b0;
            fc_value       <= 32'd0;
            thr_q          <= 32'd0;
            n_q            <= 32'd0;
            t_q            <= '0;
            wd_q           <= 32'd0;
        end else begin
            // Single-cycle pulse: low everywhere except the ISSUE cycle, so
            // the edge-triggered counter always sees a fresh rising edge.
            fc_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        thr_q <= threshold;
                        n_q   <= 32'd0;
                        t_q   <= '0;
                        done  <= 1'b0;
                        error <= 2'd0;
                        busy  <= 1'b1;
                        state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    n_q <= n_inc;
                    if (ovf) begin
                        error          <= 2'd1;
                        found_index    <= n_inc;
                        found_value    <= 32'd0;
                        found_divisors <= 32'd0;
                        state          <= S_FINISH;
                    end else begin
                        t_q      <= t_wide[VALUE_W-1:0];
                        fc_value <= t_wide[31:0];
                        fc_start <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_q  <= 32'd0;
                    state <= S_WAIT_CLR;
                end
                S_WAIT_CLR: begin
                    // A done left high by the previous evaluation is stale;
                    // wait for the counter to acknowledge the new start.
                    wd_q <= wd_q + 32'd1;
                    if (!fc_done) begin
                        state <= S_WAIT_DONE;
                    end else if (wd_hit) begin
                        error          <= 2'd2;
                        found_index    <= n_q;
                        found_value    <= 32'd0;
                        found_divisors <= 32'd0;
                        state          <= S_FINISH;
                    end
                end
                S_WAIT_DONE: begin
                    wd_q <= wd_q + 32'd1;
                    if (fc_done) begin
                        state <= S_CHECK;
                    end else if (wd_hit) begin
                        error          <= 2'd2;
                        found_index    <= n_q;
                        found_value    <= 32'd0;
                        found_divisors <= 32'd0;
                        state          <= S_FINISH;
                    end
                end
                S_CHECK: begin
                    if (fc_result > thr_q) begin
                        found_index    <= n_q;
                        found_value    <= fc_value;
                        found_divisors <= fc_result;
                        state          <= S_FINISH;
                    end else begin
                        state <= S_ADVANCE;
                    end
                end
                S_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_divisor_search.sv
// Purpose: directed checks of triangle_divisor_search against behavioural divisor counters.
// Latency: counter stubs answer 1-3 clks after a start edge; searches bounded by cycle budgets.
// Backpressure: none; start pulses while busy are expected to be ignored.
module tb_triangle_divisor_search;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    // Instance 0: main (VALUE_W=32), instance 1: VALUE_W=16, instance 2: timeout stub.
    logic        m_start, u_start, t_start;
    logic [31:0] m_thr, u_thr, t_thr;
    logic        m_busy, u_busy, t_busy;
    logic        m_done, u_done, t_done;
    logic [1:0]  m_err, u_err, t_err;
    logic [31:0] m_idx, u_idx, t_idx;
    logic [31:0] m_val, u_val, t_val;
    logic [31:0] m_div, u_div, t_div;
    logic        t_fcs;
    logic [31:0] t_fcv;

    // Behavioural divisor counters for instances 0 and 1; done starts high
    // to mimic a stale completion left from some earlier run.
    logic        fs_start  [2];
    logic [31:0] fs_value  [2];
    logic [31:0] fs_result [2] = '{32'd0, 32'd0};
    logic        fs_done   [2] = '{1'b1, 1'b1};
    logic        st_prev   [2] = '{1'b0, 1'b0};
    logic [31:0] st_pend   [2] = '{32'd0, 32'd0};
    logic [31:0] st_lat    [2] = '{32'd0, 32'd0};

    function automatic logic [31:0] count_div(input logic [31:0] v);
        logic [31:0] c = 32'd0;
        for (longint i = 1; i * i <= longint'(v); i++) begin
            if (longint'(v) % i == 0) c += (i * i == longint'(v)) ? 32'd1 : 32'd2;
        end
        return c;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            st_prev[k] <= fs_start[k];
            if (fs_start[k] && !st_prev[k]) begin
                fs_done[k]   <= 1'b0;
                fs_result[k] <= 32'hDEAD_BEEF;
                st_pend[k]   <= count_div(fs_value[k]);
                st_lat[k]    <= fs_value[k] % 3;
            end else if (!fs_done[k]) begin
                if (st_lat[k] == 0) begin
                    fs_done[k]   <= 1'b1;
                    fs_result[k] <= st_pend[k];
                end else begin
                    st_lat[k] <= st_lat[k] - 1;
                end
            end
        end
    end

    triangle_divisor_search #(.VALUE_W(32), .TIMEOUT_CYCLES(0)) u_main (
        .clk(clk), .rst_n(rst_n), .start(m_start), .threshold(m_thr),
        .busy(m_busy), .done(m_done), .error(m_err),
        .found_index(m_idx), .found_value(m_val), .found_divisors(m_div),
        .fc_start(fs_start[0]), .fc_value(fs_value[0]),
        .fc_result(fs_result[0]), .fc_done(fs_done[0])
    );

    triangle_divisor_search #(.VALUE_W(16), .TIMEOUT_CYCLES(0)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(u_start), .threshold(u_thr),
        .busy(u_busy), .done(u_done), .error(u_err),
        .found_index(u_idx), .found_value(u_val), .found_divisors(u_div),
        .fc_start(fs_start[1]), .fc_value(fs_value[1]),
        .fc_result(fs_result[1]), .fc_done(fs_done[1])
    );

    triangle_divisor_search #(.VALUE_W(32), .TIMEOUT_CYCLES(4)) u_tmo (
        .clk(clk), .rst_n(rst_n), .start(t_start), .threshold(t_thr),
        .busy(t_busy), .done(t_done), .error(t_err),
        .found_index(t_idx), .found_value(t_val), .found_divisors(t_div),
        .fc_start(t_fcs), .fc_value(t_fcv),
        .fc_result(32'd0), .fc_done(1'b0)
    );

    // Protocol watch on the main instance: no back-to-back start, no zero value issued.
    logic prev_fcs = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (fs_start[0] && prev_fcs) viol++;
            if (fs_start[0] && fs_value[0] == 32'd0) viol++;
        end
        prev_fcs = fs_start[0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_main(input logic [31:0] thr, input bit poke,
                            input logic [31:0] en, input logic [31:0] et,
                            input logic [31:0] ed, input string tag);
        bit ok;
        @(posedge clk); #1;
        m_thr   = thr;
        m_start = 1'b1;
        @(posedge clk); #1;
        m_start = 1'b0;
        check({tag, "_busy_rise"}, 32'(m_busy), 32'd1);
        check({tag, "_done_clr"},  32'(m_done), 32'd0);
        if (poke) begin
            repeat (20) @(posedge clk);
            #1;
            m_thr   = 32'd0;
            m_start = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            m_start = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (m_done) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done"},  32'(ok),     32'd1);
        check({tag, "_error"}, 32'(m_err),  32'd0);
        check({tag, "_index"}, m_idx,       en);
        check({tag, "_value"}, m_val,       et);
        check({tag, "_divs"},  m_div,       ed);
        check({tag, "_busy"},  32'(m_busy), 32'd0);
    endtask

    initial begin
        bit ok;
        rst_n   = 1'b0;
        m_start = 1'b0; u_start = 1'b0; t_start = 1'b0;
        m_thr   = 32'd0; u_thr = 32'd1000; t_thr = 32'd5;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(m_busy),     32'd0);
        check("rst_done",  32'(m_done),     32'd0);
        check("rst_error", 32'(m_err),      32'd0);
        check("rst_index", m_idx,           32'd0);
        check("rst_fcs",   32'(fs_start[0]), 32'd0);
        check("rst_fcv",   fs_value[0],     32'd0);
        rst_n = 1'b1;

        // Watchdog: counter never completes.
        @(posedge clk); #1;
        t_start = 1'b1;
        @(posedge clk); #1;
        t_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (t_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("tmo_done",  32'(ok),     32'd1);
        check("tmo_error", 32'(t_err),  32'd2);
        check("tmo_index", t_idx,       32'd1);
        check("tmo_value", t_val,       32'd0);
        check("tmo_divs",  t_div,       32'd0);
        check("tmo_busy",  32'(t_busy), 32'd0);

        // 16-bit accumulator overflows at n=362 (T(362)=65703).
        @(posedge clk); #1;
        u_start = 1'b1;
        @(posedge clk); #1;
        u_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (u_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("w16_done",  32'(ok),     32'd1);
        check("w16_error", 32'(u_err),  32'd1);
        check("w16_index", u_idx,       32'd362);
        check("w16_value", u_val,       32'd0);
        check("w16_divs",  u_div,       32'd0);
        check("w16_busy",  32'(u_busy), 32'd0);

        run_main(32'd5,   1'b0, 32'd7,   32'd28,    32'd6,   "th5");
        run_main(32'd0,   1'b0, 32'd1,   32'd1,     32'd1,   "th0");
        run_main(32'd3,   1'b0, 32'd3,   32'd6,     32'd4,   "th3");
        // Mid-search start with threshold 0 must be ignored.
        run_main(32'd100, 1'b1, 32'd384, 32'd73920, 32'd112, "th100");
        check("proto_viol", 32'(viol), 32'd0);

        // Reset in the middle of a long search, then a clean rerun.
        @(posedge clk); #1;
        m_thr   = 32'd500;
        m_start = 1'b1;
        @(posedge clk); #1;
        m_start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_busy && !fs_done[0] && !fs_start[0]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("mid_waiting", 32'(ok), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  32'(m_busy),      32'd0);
        check("mid_rst_done",  32'(m_done),      32'd0);
        check("mid_rst_error", 32'(m_err),       32'd0);
        check("mid_rst_index", m_idx,            32'd0);
        check("mid_rst_value", m_val,            32'd0);
        check("mid_rst_divs",  m_div,            32'd0);
        check("mid_rst_fcs",   32'(fs_start[0]), 32'd0);
        check("mid_rst_fcv",   fs_value[0],      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_main(32'd5, 1'b0, 32'd7, 32'd28, 32'd6, "rerun5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
